// File: rtl/stc_aloader.sv
// Writer side of the sparse tensor core A-operand buffer: compacts each dense row's
// nonzeros into slot order, writes data then column indices, and emits CSR row pointers.
module stc_aloader #(
   parameter int unsigned M       = 16,
   parameter int unsigned K       = 16,
   parameter int unsigned DW_MEM  = 256,
   parameter int unsigned DW_DATA = 16,
   parameter int unsigned DW_COL  = 4,
   parameter int unsigned DW_PTR  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DW_MEM-1:0]   in_data,
   output logic                write_data_en,
   output logic                write_cidx_en,
   output logic [DW_MEM-1:0]   A_data_input,
   output logic [DW_MEM-1:0]   A_colidx_input,
   output logic [DW_COL-1:0]   idx,
   output logic                rowptr_we,
   output logic [DW_PTR-1:0]   rowptr_val,
   output logic [DW_COL:0]     row_nnz,
   output logic [DW_PTR:0]     total_nnz,
   output logic                busy,
   output logic                done
);

   localparam int unsigned CW = DW_COL + 1;
   localparam int unsigned TW = DW_PTR + 1;
   localparam int unsigned AW = $clog2(DW_MEM);

   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WDATA, S_WCIDX, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [DW_COL-1:0]   row_cnt_q, row_cnt_d;
   logic [TW-1:0]       total_q, total_d;
   logic [DW_MEM-1:0]   data_q, data_d;
   logic [DW_MEM-1:0]   col_q, col_d;
   logic [CW-1:0]       nnz_q, nnz_d;
   logic [DW_COL-1:0]   idx_q, idx_d;
   logic [DW_PTR-1:0]   rp_q, rp_d;
   logic                in_ready_q, in_ready_d;
   logic                wde_q, wde_d;
   logic                wce_q, wce_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                accept_c;
   logic                last_row_c;
   logic [DW_MEM-1:0]   cdata_c;
   logic [DW_MEM-1:0]   ccol_c;
   logic [CW-1:0]       cnt_c;

   assign accept_c   = (state_q == S_RECV) && in_valid;
   assign last_row_c = (row_cnt_q == DW_COL'(M - 1));

   // Compaction: nonzero elements fill slots in ascending column order
   always_comb begin
      cdata_c = '0;
      ccol_c  = '0;
      cnt_c   = '0;
      for (int j = 0; j < int'(K); j++) begin
         if (in_data[j*DW_DATA +: DW_DATA] != '0) begin
            cdata_c[AW'(32'(cnt_c) * DW_DATA) +: DW_DATA] = in_data[j*DW_DATA +: DW_DATA];
            ccol_c[AW'(32'(cnt_c) * DW_COL) +: DW_COL]    = DW_COL'(j);
            cnt_c = cnt_c + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RECV;
         S_RECV:  if (in_valid) state_d = S_WDATA;
         S_WDATA: state_d = S_WCIDX;
         S_WCIDX: state_d = last_row_c ? S_DONE : S_RECV;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes decode the upcoming state so they appear registered in that state
   always_comb begin
      row_cnt_d  = row_cnt_q;
      total_d    = total_q;
      data_d     = data_q;
      col_d      = col_q;
      nnz_d      = nnz_q;
      idx_d      = idx_q;
      rp_d       = rp_q;
      in_ready_d = (state_d == S_RECV);
      wde_d      = (state_d == S_WDATA);
      wce_d      = (state_d == S_WCIDX);
      busy_d     = (state_d != S_IDLE);
      done_d     = (state_d == S_DONE);
      if ((state_q == S_IDLE) && start) begin
         row_cnt_d = '0;
         total_d   = '0;
      end
      if (accept_c) begin
         data_d = cdata_c;
         col_d  = ccol_c;
         nnz_d  = cnt_c;
         idx_d  = row_cnt_q;
         rp_d   = total_q[DW_PTR-1:0];
      end
      if (state_q == S_WDATA) total_d = total_q + TW'(nnz_q);
      if ((state_q == S_WCIDX) && !last_row_c) row_cnt_d = row_cnt_q + DW_COL'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_cnt_q  <= '0;
         total_q    <= '0;
         data_q     <= '0;
         col_q      <= '0;
         nnz_q      <= '0;
         idx_q      <= '0;
         rp_q       <= '0;
         in_ready_q <= 1'b0;
         wde_q      <= 1'b0;
         wce_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         row_cnt_q  <= row_cnt_d;
         total_q    <= total_d;
         data_q     <= data_d;
         col_q      <= col_d;
         nnz_q      <= nnz_d;
         idx_q      <= idx_d;
         rp_q       <= rp_d;
         in_ready_q <= in_ready_d;
         wde_q      <= wde_d;
         wce_q      <= wce_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign write_data_en  = wde_q;
   assign write_cidx_en  = wce_q;
   assign rowptr_we      = wde_q;
   assign A_data_input   = data_q;
   assign A_colidx_input = col_q;
   assign idx            = idx_q;
   assign rowptr_val     = rp_q;
   assign row_nnz        = nnz_q;
   assign total_nnz      = total_q;
   assign busy           = busy_q;
   assign done           = done_q;

endmodule

// File: tb/tb_stc_aloader.sv
// Randomized scoreboard bench for stc_aloader: the driver pushes the expected compacted
// row per accepted input, and a negedge monitor checks each write strobe pair against it.
module tb_stc_aloader;

   localparam int M = 16;
   localparam int K = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [255:0] in_data = '0;
   logic         write_data_en, write_cidx_en, rowptr_we, busy, done;
   logic [255:0] A_data_input, A_colidx_input;
   logic [3:0]   idx;
   logic [7:0]   rowptr_val;
   logic [4:0]   row_nnz;
   logic [8:0]   total_nnz;

   stc_aloader dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .write_data_en(write_data_en), .write_cidx_en(write_cidx_en),
      .A_data_input(A_data_input), .A_colidx_input(A_colidx_input), .idx(idx),
      .rowptr_we(rowptr_we), .rowptr_val(rowptr_val), .row_nnz(row_nnz),
      .total_nnz(total_nnz), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] data;
      logic [255:0] col;
      int           nnz;
      int           idx;
      int           rp;
      int           tot;
      bit           last;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;
   int   ndone = 0;
   int   row_i = 0;
   int   tot = 0;
   bit   pend = 0;
   bit   exp_done = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: list the nonzeros, then lay them out slot by slot
   function automatic exp_t model(input logic [255:0] row);
      exp_t        e;
      logic [15:0] vals[$];
      int          cols[$];
      logic [15:0] el;
      for (int j = 0; j < K; j++) begin
         el = row[j*16 +: 16];
         if (el != 16'd0) begin
            vals.push_back(el);
            cols.push_back(j);
         end
      end
      e.data = '0;
      e.col  = '0;
      foreach (vals[s]) begin
         e.data[s*16 +: 16] = vals[s];
         e.col[s*4 +: 4]    = 4'(cols[s]);
      end
      e.nnz  = vals.size();
      e.idx  = row_i;
      e.rp   = tot % 256;
      e.tot  = tot + e.nnz;
      e.last = (row_i == M - 1);
      return e;
   endfunction

   function automatic logic [255:0] rand_row(input int pct);
      logic [255:0] r = '0;
      for (int j = 0; j < K; j++)
         if ($urandom_range(99) < pct) r[j*16 +: 16] = 16'($urandom_range(65535, 1));
      return r;
   endfunction

   function automatic logic [255:0] garbage();
      logic [255:0] r;
      for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic send_row(input logic [255:0] row, input int vprob, output int iters);
      bit   ok = 0;
      exp_t e;
      iters = 0;
      for (int it = 0; it < 60 && !ok; it++) begin
         in_valid = ($urandom_range(99) < vprob);
         in_data  = in_valid ? row : garbage();
         @(negedge clk);
         ok = in_valid && in_ready;
         @(posedge clk);
         #1;
         iters++;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      else begin
         e = model(row);
         q.push_back(e);
         row_i++;
         tot += e.nnz;
      end
   endtask

   task automatic start_mat();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      row_i = 0;
      tot   = 0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      in_valid = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = !busy;
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   task automatic check_zero(input string name);
      chk(name, {in_ready, write_data_en, write_cidx_en, rowptr_we, busy, done,
                 idx, rowptr_val, row_nnz, total_nnz}, '0);
      chk({name, "_data"}, A_data_input, '0);
      chk({name, "_colidx"}, A_colidx_input, '0);
   endtask

   // Monitor: data strobe checks the queue head, the index strobe must follow next cycle
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         pend     = 0;
         exp_done = 0;
      end else begin
         if (done) ndone++;
         if (done || exp_done) chk("done_pulse", done, exp_done);
         exp_done = 0;
         if (write_data_en && write_cidx_en) chk("strobe_overlap", 1, 0);
         if (write_data_en) begin
            if (q.size() == 0 || pend) chk("unexpected_data_strobe", 1, 0);
            else begin
               e = q[0];
               chk("data", A_data_input, e.data);
               chk("colidx", A_colidx_input, e.col);
               chk("row_nnz", row_nnz, e.nnz);
               chk("idx_wdata", idx, e.idx);
               chk("rowptr_val", rowptr_val, e.rp);
               chk("rowptr_we", rowptr_we, 1);
               pend = 1;
            end
         end else if (write_cidx_en) begin
            if (!pend || q.size() == 0) chk("unexpected_cidx_strobe", 1, 0);
            else begin
               e = q.pop_front();
               chk("idx_wcidx", idx, e.idx);
               chk("total_nnz", total_nnz, e.tot);
               chk("colidx_hold", A_colidx_input, e.col);
               chk("rowptr_we_low", rowptr_we, 0);
               pend = 0;
               if (e.last) exp_done = 1;
            end
         end else if (pend) begin
            chk("cidx_after_data", 0, 1);
            pend = 0;
            void'(q.pop_front());
         end
      end
   end

   initial begin
      int           it;
      logic [255:0] row;

      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_zero("reset_outputs");
      reset = 1'b1;

      // identity matrix, in_valid held high
      start_mat();
      for (int i = 0; i < M; i++) begin
         row = '0;
         row[i*16 +: 16] = 16'd1;
         send_row(row, 100, it);
         if (i > 0) chk("throughput_gap", it, 3);
      end
      wait_idle();
      chk("identity_total", total_nnz, 16);

      // sparse row, zero row, dense row, then random fill
      start_mat();
      row = '0;
      row[3*16 +: 16]  = 16'hA;
      row[7*16 +: 16]  = 16'hB;
      row[15*16 +: 16] = 16'hC;
      send_row(row, 100, it);
      send_row('0, 100, it);
      for (int j = 0; j < K; j++) row[j*16 +: 16] = 16'(j + 1);
      send_row(row, 100, it);
      for (int i = 3; i < M; i++) send_row(rand_row(50), 70, it);
      wait_idle();

      // fully dense matrix reaches 256 without wrap
      start_mat();
      for (int i = 0; i < M; i++) send_row(rand_row(100), 100, it);
      wait_idle();
      chk("dense_total", total_nnz, 256);

      // random in_valid with a spurious start mid-matrix
      start_mat();
      for (int i = 0; i < M; i++) begin
         if (i == 7) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
         end
         send_row(rand_row(40), 50, it);
      end
      wait_idle();

      // abort during WDATA of row 5, then a clean restart
      start_mat();
      for (int i = 0; i < 6; i++) send_row(rand_row(60), 100, it);
      @(negedge clk);
      #1 reset = 1'b0;
      #1 check_zero("abort_outputs");
      q.delete();
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      start_mat();
      for (int i = 0; i < M; i++) send_row(rand_row(50), 60, it);
      wait_idle();

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      chk("done_count", ndone, 5);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/stc_aloader.md
Name: stc_Aloader

Overview:
- Writer side of the A-operand buffer in the unstructured sparse tensor core.
- Accepts dense A rows one at a time: K elements of DW_DATA each, packed into DW_MEM bits.
- Compacts each row's nonzero elements into slot order and generates the matching packed column indices.
- Drives the buffer's write_data_en / write_cidx_en / idx / A_data_input / A_colidx_input write port, and emits row pointers (CSR offsets) for the pointer-based read side.

Parameters:
M, 16, number of rows per matrix
K, 16, elements per row
DW_MEM, 256, width of a row word (K*DW_DATA <= DW_MEM)
DW_DATA, 16, element width
DW_COL, 4, column index width (2^DW_COL >= K)
DW_PTR, 8, row pointer width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse, begin loading an M-row matrix
in_valid  input  1  in_data holds a valid dense row
in_ready  output  1  loader accepts a row this cycle
in_data  input  DW_MEM  dense row; element j at [j*DW_DATA +: DW_DATA]
write_data_en  output  1  buffer data write strobe
write_cidx_en  output  1  buffer column-index write strobe
A_data_input  output  DW_MEM  compacted nonzero data
A_colidx_input  output  DW_MEM  compacted column indices
idx  output  DW_COL  buffer row index being written
rowptr_we  output  1  row pointer valid
rowptr_val  output  DW_PTR  nnz offset of the start of row idx
row_nnz  output  DW_COL+1  nonzero count of current row
total_nnz  output  DW_PTR+1  running nonzero total
busy  output  1  FSM not IDLE
done  output  1  one-cycle pulse after last row written

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0, including A_data_input, A_colidx_input, idx, total_nnz.
- Reset asserted mid-operation aborts the matrix. No further write strobes until a new start.
- States: IDLE, RECV, WDATA, WCIDX, DONE.
- IDLE: on start, go to RECV; clear row counter and total_nnz.
- RECV: in_ready=1. On in_valid && in_ready (cycle t), register the row, compact it, and go to WDATA.
- in_ready is 0 in every state other than RECV.
- Compaction:
  - Element j is nonzero if any bit is set.
  - Nonzeros are placed in ascending j order into slots s=0..n-1.
  - Data goes to A_data_input[s*DW_DATA +: DW_DATA]; column j goes to A_colidx_input[s*DW_COL +: DW_COL].
  - Unused slots and all bits above K*DW_DATA (data) or K*DW_COL (indices) are 0.
- WDATA (cycle t+1):
  - write_data_en=1 and rowptr_we=1.
  - idx = row counter.
  - rowptr_val = total_nnz before this row, truncated to DW_PTR.
  - row_nnz = n.
  - Next state WCIDX.
- WCIDX (cycle t+2):
  - write_cidx_en=1; idx unchanged.
  - total_nnz += n.
  - If row counter == M-1, go to DONE; else increment the row counter and go to RECV.
- DONE: done=1 for exactly one cycle, then IDLE.
- Strobes are single-cycle and never simultaneous. A_data_input, A_colidx_input and idx hold their values until the next row is accepted.
- start is ignored while busy.
- in_valid outside RECV has no effect; the row is not consumed.
- Rows with n=0 still produce both write strobes, with zero payloads.
- Per-row throughput: 3 cycles minimum. Back-to-back in_valid rows are accepted every 3rd cycle.
- Full rows: n=K=16 fits in row_nnz (5 bits). total_nnz reaches 256 for M=K=16, so it is DW_PTR+1 bits wide.

Test Plan:
- Identity matrix (row i has 1 at column i), in_valid held high:
  - each row writes A_data_input[15:0]=1 and A_colidx_input[3:0]=i, with all other bits 0;
  - rowptr_val=i, row_nnz=1;
  - done pulses once; total_nnz=16.
- Row with elements at columns 3, 7, 15 (values 0xA, 0xB, 0xC) ->
  - data slots 0..2 = 0xA, 0xB, 0xC;
  - col slots = 3, 7, 15;
  - row_nnz=3;
  - write_data_en at t+1, write_cidx_en at t+2.
- All-zero row then fully dense row (values 1..16) ->
  - first row: row_nnz=0, zero payloads, both strobes present;
  - second row: cols 0..15 in order, rowptr_val unchanged from the prior row's start, total_nnz increases by 16.
- All 16 rows dense ->
  - rowptr_val sequence is 0, 16, …, 240;
  - final total_nnz=256 with no wrap.
- in_valid toggled randomly, plus a start pulse mid-matrix ->
  - rows are consumed only when in_ready=1;
  - the spurious start is ignored;
  - idx increments 0..15 with no skips.
- Reset dropped low during WDATA of row 5 ->
  - all outputs 0 immediately; no write_cidx_en for row 5;
  - a new start restarts from idx=0 with total_nnz=0.
